rgmii_tx_multispeed: RTL
========================

RGMII_TX_MULTISPEED -- requirements
Module: rgmii_tx_multispeed

Interface
REQ-001 Parameter DIV_100, default 5, meaning clk cycles per TXC period in 100M mode (125 MHz clk to 25 MHz); legal range >=2.
REQ-002 Parameter DIV_10, default 50, meaning clk cycles per TXC period in 10M mode (125 MHz clk to 2.5 MHz); legal range >=2.
REQ-003 clk  in  1  single clock, 125 MHz; the only clock in the block.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 speed  in  2  requested mode: 00=10M, 01=100M, 10=1000M, 11 treated as 1000M.
REQ-006 mac_phy_txen  in  1  byte valid / frame active for the current byte.
REQ-007 mac_phy_txer  in  1  transmit error for the current byte.
REQ-008 mac_phy_txd  in  8  byte to send; low nibble goes first.
REQ-009 mac_phy_ready  out  1  byte slot boundary; mac_phy_txen, mac_phy_txer and mac_phy_txd are consumed in each cycle where this is high.
REQ-010 active_speed  out  2  latched mode currently in effect.
REQ-011 phy_txc  out  1  forwarded DDR transmit clock.
REQ-012 phy_txctl  out  1  DDR control: first edge txen, second edge txen XOR txer.
REQ-013 phy_txd  out  4  DDR data.

Function
REQ-014 All three pins shall be driven through the existing oddr primitive (d1 = rising-edge half, d2 = falling-edge half); oddr latency L is identical for every pin.
REQ-015 1000M: mac_phy_ready=1 every cycle; per consumed byte: txd d1=txd[3:0], d2=txd[7:4]; txctl d1=txen, d2=txen^txer; txc d1=1, d2=0.
REQ-016 10/100M: DIV = DIV_100 or DIV_10; phase counter c counts 0..DIV-1 and wraps; nibble flag n toggles on each wrap; byte slot = 2*DIV cycles.
REQ-017 10/100M txc: d1=(2c<DIV), d2=(2c+1<DIV); so txc is high for exactly DIV half-cycles per period (DIV=5 gives 2.5 cycles high, 2.5 cycles low).
REQ-018 10/100M data: for n=0 drive txd[3:0], for n=1 drive txd[7:4], on both d1 and d2, held for all DIV cycles; txctl d1=txen, d2=txen^txer, held for the whole slot.
REQ-019 10/100M mac_phy_ready is high only in the cycle where c=DIV-1 and n=1; the byte consumed there starts on the next cycle with c=0, n=0.
REQ-020 Consumed byte registers: the core d1/d2 registers update one cycle after consumption; pins follow after further latency L; total latency is L+1 cycles in all modes.
REQ-021 With txen=0 in a consumed slot, the block sends idle: txd=0, txctl=0/0, txc keeps running.
REQ-022 speed is sampled only at a slot boundary where the byte consumed in that cycle and the previous consumed byte both have txen=0.
REQ-023 A speed change mid-frame shall be ignored until the first qualifying boundary after the frame.
REQ-024 On a speed change, active_speed updates, and c and n restart at 0 in the next cycle.
REQ-025 txen is not re-checked mid-slot; inputs outside ready cycles are ignored.

Reset
REQ-026 During rst: c=0, n=0, all oddr d1/d2 inputs 0, oddr rst asserted, so phy_txc, phy_txctl and phy_txd are 0.
REQ-027 During rst: mac_phy_ready=0; active_speed loads speed (11 loads as 10).
REQ-028 rst asserted mid-frame aborts the frame immediately, with no partial nibble completion.
REQ-029 First cycle after rst release: c=0, n=0; 1000M ready=1; 10/100M first ready occurs at cycle 2*DIV-1.

Structure
REQ-030 Shared package rgmii_pkg shall hold the speed encoding constants (SPEED_10, SPEED_100, SPEED_1000) and the default DIV_100/DIV_10 values.
REQ-031 Sub-module rgmii_txc_gen shall own c, n, the txc d1/d2 pattern and the ready strobe; the top instantiates it plus three oddr instances (txc, txctl, txd).

Verification
REQ-032 1000M, bytes 0xA5,0x3C with txen=1 -> pins after L+1: rise 5/fall A, then rise C/fall 3; txctl 1/1; ready constant 1.
REQ-033 100M, DIV=5, byte 0x5D with txer=1 -> txd=D for 5 cycles then 5 for 5 cycles; txctl 1/0; txc high 5 half-cycles per 10; ready every 10 cycles.
REQ-034 10M, DIV=50, 4-byte frame then idle -> ready period 100 cycles; txd/txctl 0 after the frame; txc keeps a 50% duty cycle.
REQ-035 speed switched 10->1000M mid-frame -> active_speed unchanged until the frame ends plus one idle slot, then 10; counters restart; ready goes high continuously.
REQ-036 rst pulsed mid-byte in 100M -> all pins 0 within L cycles; first ready 9 cycles after release; speed=11 at reset gives active_speed=10.

Source files
------------

// File: rtl/rgmii_tx_multispeed_pkg.sv
// Shared constants and types for the multispeed RGMII transmitter.
package rgmii_pkg;

  localparam logic [1:0] SPEED_10   = 2'b00;
  localparam logic [1:0] SPEED_100  = 2'b01;
  localparam logic [1:0] SPEED_1000 = 2'b10;

  localparam int DIV_100_DEFAULT = 5;
  localparam int DIV_10_DEFAULT  = 50;

  localparam int CNT_W = 16;

  typedef struct packed {
    logic       txen;
    logic       txer;
    logic [7:0] txd;
  } tx_byte_t;

  // Encoding 11 is an alias for gigabit.
  function automatic logic [1:0] norm_speed(input logic [1:0] s);
    return (s == 2'b11) ? SPEED_1000 : s;
  endfunction

endpackage

// File: rtl/rgmii_tx_multispeed_if.sv
// MAC-side byte interface: the MAC offers a byte, the transmitter strobes ready when it takes it.
interface rgmii_tx_multispeed_if;
  logic       mac_phy_txen;
  logic       mac_phy_txer;
  logic [7:0] mac_phy_txd;
  logic       mac_phy_ready;

  modport master (output mac_phy_txen, mac_phy_txer, mac_phy_txd, input mac_phy_ready);
  modport slave  (input mac_phy_txen, mac_phy_txer, mac_phy_txd, output mac_phy_ready);
endinterface

// File: rtl/oddr.sv
// DDR output register: d1 drives the high half of the next clk cycle, d2 the low half.
module oddr #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= d1;
      fall_q <= d2;
    end
  end

  assign q = clk ? rise_q : fall_q;
endmodule

// File: rtl/rgmii_tx_multispeed_txc_gen.sv
// Phase counter, nibble flag, forwarded-clock pattern and byte-slot strobe.
module rgmii_txc_gen
  import rgmii_pkg::*;
#(
  parameter int DIV_100 = DIV_100_DEFAULT,
  parameter int DIV_10  = DIV_10_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  input  logic [1:0] active_speed,
  output logic       nib,
  output logic       txc_d1,
  output logic       txc_d2,
  output logic       ready
);
  localparam logic [CNT_W-1:0] DIV_100_W = CNT_W'(DIV_100);
  localparam logic [CNT_W-1:0] DIV_10_W  = CNT_W'(DIV_10);

  logic [CNT_W-1:0] c;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] c_last;
  logic             gig;

  always_comb begin
    gig    = (active_speed == SPEED_1000);
    div    = (active_speed == SPEED_10) ? DIV_10_W : DIV_100_W;
    c_last = div - CNT_W'(1);
  end

  // Counters park at zero in gigabit so a later downshift starts on a clean slot.
  always_ff @(posedge clk) begin
    if (rst || restart || gig) begin
      c   <= '0;
      nib <= 1'b0;
    end else if (c == c_last) begin
      c   <= '0;
      nib <= ~nib;
    end else begin
      c <= c + CNT_W'(1);
    end
  end

  // Half-cycle h of the period is high while h < DIV, giving 50% duty for odd DIV too.
  always_comb begin
    txc_d1 = 1'b0;
    txc_d2 = 1'b0;
    ready  = 1'b0;
    if (!rst) begin
      if (gig) begin
        txc_d1 = 1'b1;
        ready  = 1'b1;
      end else begin
        txc_d1 = ({c, 1'b0} < {1'b0, div});
        txc_d2 = ({c, 1'b1} < {1'b0, div});
        ready  = (c == c_last) && nib;
      end
    end
  end
endmodule

// File: rtl/rgmii_tx_multispeed.sv
// RGMII transmitter for 10/100/1000M from a single 125 MHz clock; speed changes only between frames.
module rgmii_tx_multispeed
  import rgmii_pkg::*;
#(
  parameter int DIV_100 = DIV_100_DEFAULT,
  parameter int DIV_10  = DIV_10_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  speed,
  rgmii_tx_multispeed_if.slave        mac,
  output logic [1:0]                  active_speed,
  output logic                        phy_txc,
  output logic                        phy_txctl,
  output logic [3:0]                  phy_txd
);
  tx_byte_t   byte_q;
  logic       prev_txen;
  logic       ready;
  logic       nib;
  logic       gig;
  logic       speed_change;
  logic       txc_d1, txc_d2;
  logic       ctl_d1, ctl_d2;
  logic [3:0] txd_d1, txd_d2;
  logic [3:0] nibble;

  assign gig              = (active_speed == SPEED_1000);
  assign mac.mac_phy_ready = ready;

  // Two idle bytes in a row guarantee no frame is cut by the switch.
  assign speed_change = ready && !mac.mac_phy_txen && !prev_txen &&
                        (norm_speed(speed) != active_speed);

  always_ff @(posedge clk) begin
    if (rst) begin
      active_speed <= norm_speed(speed);
      byte_q       <= '0;
      prev_txen    <= 1'b0;
    end else if (ready) begin
      byte_q    <= {mac.mac_phy_txen, mac.mac_phy_txer, mac.mac_phy_txd};
      prev_txen <= mac.mac_phy_txen;
      if (speed_change) begin
        active_speed <= norm_speed(speed);
      end
    end
  end

  rgmii_txc_gen #(
    .DIV_100 (DIV_100),
    .DIV_10  (DIV_10)
  ) u_txc_gen (
    .clk          (clk),
    .rst          (rst),
    .restart      (speed_change),
    .active_speed (active_speed),
    .nib          (nib),
    .txc_d1       (txc_d1),
    .txc_d2       (txc_d2),
    .ready        (ready)
  );

  always_comb begin
    nibble = nib ? byte_q.txd[7:4] : byte_q.txd[3:0];
    txd_d1 = '0;
    txd_d2 = '0;
    ctl_d1 = 1'b0;
    ctl_d2 = 1'b0;
    if (!rst && byte_q.txen) begin
      ctl_d1 = 1'b1;
      ctl_d2 = ~byte_q.txer;
      if (gig) begin
        txd_d1 = byte_q.txd[3:0];
        txd_d2 = byte_q.txd[7:4];
      end else begin
        txd_d1 = nibble;
        txd_d2 = nibble;
      end
    end
  end

  oddr #(.WIDTH(1)) u_oddr_txc (
    .clk (clk), .rst (rst), .d1 (txc_d1), .d2 (txc_d2), .q (phy_txc)
  );

  oddr #(.WIDTH(1)) u_oddr_txctl (
    .clk (clk), .rst (rst), .d1 (ctl_d1), .d2 (ctl_d2), .q (phy_txctl)
  );

  oddr #(.WIDTH(4)) u_oddr_txd (
    .clk (clk), .rst (rst), .d1 (txd_d1), .d2 (txd_d2), .q (phy_txd)
  );
endmodule
